// File: rtl/gate_equiv_checker_pkg.sv
// Shared definitions for the gate equivalence checker: FSM state encoding and
// default sweep geometry.
package gate_equiv_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int DEF_N_IN   = 2;
  localparam int DEF_SETTLE = 1;

endpackage

// File: rtl/gate_equiv_checker_minterm_counter.sv
// Minterm index and settle timer for the sweep. m saturates at the last
// minterm, so x_out keeps showing it once the sweep has finished.
module minterm_counter
  import gate_equiv_checker_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            step,
  output logic [N_IN-1:0] m,
  output logic            settled,
  output logic            last
);

  localparam int SC_W = $clog2(SETTLE + 1);

  logic [SC_W-1:0] sc;

  // settled is high on the SETTLE-th cycle of a minterm and holds through SAMPLE
  assign settled = (sc == SC_W'(SETTLE - 1));
  assign last    = &m;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      m  <= '0;
      sc <= '0;
    end else if (step) begin
      if (!last) m <= m + N_IN'(1);
      sc <= '0;
    end else if (!settled) begin
      sc <= sc + SC_W'(1);
    end
  end

endmodule

// File: rtl/gate_equiv_checker.sv
// Sweeps every minterm onto two combinational gates, captures both truth
// tables and reports where and how often they disagree.
module gate_equiv_checker
  import gate_equiv_checker_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [N_IN-1:0]      x_out,
  input  logic                 a_in,
  input  logic                 b_in,
  output logic                 busy,
  output logic                 done,
  output logic                 equal,
  output logic [2**N_IN-1:0]   tt_a,
  output logic [2**N_IN-1:0]   tt_b,
  output logic [2**N_IN-1:0]   mismatch_mask,
  output logic [N_IN:0]        mismatch_count,
  output logic [N_IN-1:0]      first_mismatch
);

  state_t          state;
  logic [N_IN-1:0] m;
  logic            settled;
  logic            last;
  logic            clr;
  logic            step;

  assign clr   = (state == ST_IDLE) && start;
  assign step  = (state == ST_SAMPLE);
  assign x_out = m;

  minterm_counter #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) u_counter (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .step    (step),
    .m       (m),
    .settled (settled),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      equal          <= 1'b0;
      tt_a           <= '0;
      tt_b           <= '0;
      mismatch_mask  <= '0;
      mismatch_count <= '0;
      first_mismatch <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state          <= ST_DRIVE;
            busy           <= 1'b1;
            equal          <= 1'b0;
            tt_a           <= '0;
            tt_b           <= '0;
            mismatch_mask  <= '0;
            mismatch_count <= '0;
            first_mismatch <= '0;
          end
        end
        ST_DRIVE: begin
          if (settled) state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          tt_a[m] <= a_in;
          tt_b[m] <= b_in;
          if (a_in != b_in) begin
            mismatch_mask[m] <= 1'b1;
            mismatch_count   <= mismatch_count + (N_IN + 1)'(1);
            // count still zero means this is the first disagreement of the sweep
            if (mismatch_count == '0) first_mismatch <= m;
          end
          state <= last ? ST_DONE : ST_DRIVE;
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          equal <= (mismatch_count == '0);
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
